// File: rtl/dpram_init_bypass_if.sv
// Bus bundle for dpram_init_bypass: write port, read port, clear request and status.
// The master drives the requests and the slave (the RAM) drives data and status back.
interface dpram_init_bypass_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              we;
  logic [ADDR_W-1:0] wr_add;
  logic [DATA_W-1:0] d;
  logic              re;
  logic [ADDR_W-1:0] rd_add;
  logic              clr;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              init_busy;

  modport master (
    output we, wr_add, d, re, rd_add, clr,
    input  q, q_valid, init_busy
  );

  modport slave (
    input  we, wr_add, d, re, rd_add, clr,
    output q, q_valid, init_busy
  );
endinterface

// File: rtl/dpram_init_bypass.sv
// Single-clock dual-port RAM with a registered read, a selectable read-during-write result,
// and a sequencer that fills every word with CLR_VAL after reset or on a clear request.
module dpram_init_bypass #(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 10,
  parameter bit                BYPASS  = 1'b1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  dpram_init_bypass_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              rdValid_q, rdValid_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic              collide;

  assign collide = bus.we && bus.re && (bus.wr_add == bus.rd_add);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      ptr_q     <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
    end
  end

  // The sequencer owns the single write port while INIT; a clr edge performs no access at all.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rdData_d  = rdData_q;
    rdValid_d = 1'b0;
    memWe     = 1'b0;
    memAddr   = bus.wr_add;
    memData   = bus.d;
    unique case (state_q)
      INIT: begin
        memWe   = 1'b1;
        memAddr = ptr_q;
        memData = CLR_VAL;
        if (ptr_q == '1) begin
          state_d = RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      RUN: begin
        if (bus.clr) begin
          state_d = INIT;
          ptr_d   = '0;
        end else begin
          memWe = bus.we;
          if (bus.re) begin
            rdValid_d = 1'b1;
            rdData_d  = (BYPASS && collide) ? bus.d : mem[bus.rd_add];
          end
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // The array has no reset: contents survive rst until the sequencer overwrites them.
  always_ff @(posedge clk) begin
    if (!rst && memWe) begin
      mem[memAddr] <= memData;
    end
  end

  assign bus.q         = rdData_q;
  assign bus.q_valid   = rdValid_q;
  assign bus.init_busy = (state_q == INIT);

endmodule

// File: tb/tb_dpram_init_bypass.sv
// Drives a BYPASS=1 and a BYPASS=0 instance with identical traffic and checks both every cycle
// against an array-based model of the memory, plus literal expectations from the directed tests.
module tb_dpram_init_bypass;

  localparam int         DEPTH = 16;
  localparam logic [7:0] CLR   = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [3:0] wrAdd = '0, rdAdd = '0;
  logic [7:0] dIn = '0;

  int assertCount = 0;
  int failCount   = 0;

  dpram_init_bypass_if #(.DATA_W(8), .ADDR_W(4)) ifA ();
  dpram_init_bypass_if #(.DATA_W(8), .ADDR_W(4)) ifB ();

  assign ifA.we = we;  assign ifA.wr_add = wrAdd;  assign ifA.d = dIn;
  assign ifA.re = re;  assign ifA.rd_add = rdAdd;  assign ifA.clr = clr;
  assign ifB.we = we;  assign ifB.wr_add = wrAdd;  assign ifB.d = dIn;
  assign ifB.re = re;  assign ifB.rd_add = rdAdd;  assign ifB.clr = clr;

  dpram_init_bypass #(.DATA_W(8), .ADDR_W(4), .BYPASS(1'b1), .CLR_VAL(CLR)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );
  dpram_init_bypass #(.DATA_W(8), .ADDR_W(4), .BYPASS(1'b0), .CLR_VAL(CLR)) dutB (
    .clk(clk), .rst(rst), .bus(ifB)
  );

  always #5 clk = ~clk;

  // Reference model: word array, remaining clear edges, and expected read outputs per mode.
  logic [7:0] modelMem [DEPTH];
  int         initLeft   = DEPTH;
  logic [7:0] expQA      = '0;
  logic [7:0] expQB      = '0;
  logic       expValid   = 1'b0;
  bit         modelReady = 1'b0;

  always @(posedge clk) begin
    logic [7:0] old;
    if (rst) begin
      initLeft   = DEPTH;
      expQA      = '0;
      expQB      = '0;
      expValid   = 1'b0;
      modelReady = 1'b1;
    end else if (initLeft > 0) begin
      modelMem[DEPTH - initLeft] = CLR;
      initLeft = initLeft - 1;
      expValid = 1'b0;
    end else if (clr) begin
      initLeft = DEPTH;
      expValid = 1'b0;
    end else begin
      if (re) begin
        old      = modelMem[rdAdd];
        expValid = 1'b1;
        expQB    = old;
        expQA    = (we && wrAdd == rdAdd) ? dIn : old;
      end else begin
        expValid = 1'b0;
      end
      if (we) modelMem[wrAdd] = dIn;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("busyA",  {7'b0, ifA.init_busy}, {7'b0, initLeft > 0});
      checkOutput("busyB",  {7'b0, ifB.init_busy}, {7'b0, initLeft > 0});
      checkOutput("validA", {7'b0, ifA.q_valid},   {7'b0, expValid});
      checkOutput("validB", {7'b0, ifB.q_valid},   {7'b0, expValid});
      checkOutput("qA",     ifA.q,                 expQA);
      checkOutput("qB",     ifB.q,                 expQB);
    end
  end

  // Sets all inputs, then returns just after the edge that samples them.
  task automatic applyStimulus(input logic iWe, input logic [3:0] iWa, input logic [7:0] iD,
                               input logic iRe, input logic [3:0] iRa, input logic iClr,
                               input logic iRst);
    we = iWe; wrAdd = iWa; dIn = iD; re = iRe; rdAdd = iRa; clr = iClr; rst = iRst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic writeWord(input logic [3:0] a, input logic [7:0] v);
    applyStimulus(1'b1, a, v, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic readWord(input logic [3:0] a);
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, a, 1'b0, 1'b0);
  endtask

  // Counts rst-low edges until init_busy falls, bounded so a stuck sequencer cannot hang the run.
  task automatic countBusy(output int edges);
    edges = 0;
    while (ifA.init_busy && edges < 40) begin
      idle();
      edges++;
    end
  endtask

  initial begin
    int edges;
    logic [3:0] a;

    $display("[TB] reset and clear");
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("rstQ",     ifA.q,                 8'h00);
    checkOutput("rstValid", {7'b0, ifA.q_valid},   8'h00);
    checkOutput("rstBusy",  {7'b0, ifA.init_busy}, 8'h01);
    countBusy(edges);
    checkOutput("initEdges", 8'(edges), 8'd16);
    checkOutput("idleQ", ifA.q, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      readWord(4'(i));
      checkOutput("clearRead", ifA.q, CLR);
      checkOutput("clearValid", {7'b0, ifA.q_valid}, 8'h01);
    end

    $display("[TB] basic write and read");
    writeWord(4'd2, 8'hD3);
    readWord(4'd3);
    checkOutput("read3", ifA.q, 8'hA5);
    readWord(4'd2);
    checkOutput("read2", ifA.q, 8'hD3);
    checkOutput("read2Valid", {7'b0, ifA.q_valid}, 8'h01);

    $display("[TB] collision");
    writeWord(4'd5, 8'h11);
    applyStimulus(1'b1, 4'd5, 8'h22, 1'b1, 4'd5, 1'b0, 1'b0);
    checkOutput("collideNew", ifA.q, 8'h22);
    checkOutput("collideOld", ifB.q, 8'h11);
    readWord(4'd5);
    checkOutput("afterCollideA", ifA.q, 8'h22);
    checkOutput("afterCollideB", ifB.q, 8'h22);

    $display("[TB] ports ignored during INIT");
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 4'd7, 8'hFF, 1'b1, 4'd7, 1'b0, 1'b0);
      checkOutput("initValid", {7'b0, ifA.q_valid}, 8'h00);
    end
    checkOutput("clrDone", {7'b0, ifA.init_busy}, 8'h00);
    readWord(4'd7);
    checkOutput("read7", ifA.q, 8'hA5);

    $display("[TB] reset mid-INIT");
    for (int i = 0; i < DEPTH; i++) writeWord(4'(i), 8'($urandom));
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) idle();
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    countBusy(edges);
    checkOutput("reinitEdges", 8'(edges), 8'd16);
    for (int i = 0; i < DEPTH; i++) begin
      readWord(4'(i));
      checkOutput("reinitRead", ifB.q, CLR);
    end

    $display("[TB] streaming");
    for (int i = 0; i < DEPTH; i++) writeWord(4'(i), 8'(i) ^ 8'h3C);
    for (int i = 0; i < DEPTH; i++) begin
      readWord(4'(i));
      checkOutput("streamQ", ifA.q, 8'(i) ^ 8'h3C);
      checkOutput("streamValid", {7'b0, ifA.q_valid}, 8'h01);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      a = 4'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15)),
                    (r >= 1 && r <= 3), (r == 0));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dpram_init_bypass.md
# dpram_init_bypass

Parametrised synchronous dual-port RAM: one write port, one read port, one clock. It is the successor to the fixed 8-bit × 1024 DPRAM, generalised in width and depth, with four additions:
- a registered read with a valid strobe;
- a selectable read-during-write collision mode;
- a hardware clear sequencer that fills every location with a constant after reset or on request;
- a busy flag that tells FSM clients when the memory is usable.

## Interface
Parameters:
- DATA_W, 8, data width in bits (≥1)
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
- BYPASS, 1, same-address read-during-write result: 1 = new data (d), 0 = old memory contents
- CLR_VAL, 0, DATA_W-bit value written to every word by the clear sequencer

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable
- wr_add  in  ADDR_W  write address
- d  in  DATA_W  write data
- re  in  1  read enable
- rd_add  in  ADDR_W  read address
- clr  in  1  clear request, honoured only in state RUN
- q  out  DATA_W  registered read data
- q_valid  out  1  high for one cycle when q carries data for a read issued on the previous edge
- init_busy  out  1  high while state is INIT; we/re ignored while high

## Operation
- State machine:
  - Two states, INIT and RUN, with an ADDR_W-bit clear pointer ptr.
  - init_busy = (state == INIT).
- Reset, rst = 1 at an edge:
  - state ← INIT, ptr ← 0, q ← 0, q_valid ← 0.
  - Memory is not written while rst is high.
  - rst takes priority over every other input.
- INIT, rst = 0:
  - Each edge writes mem[ptr] ← CLR_VAL.
  - If ptr == DEPTH-1, state ← RUN and ptr ← 0. Otherwise ptr ← ptr+1.
  - we, re, clr are ignored. q holds its value. q_valid ← 0.
- RUN, clr = 1:
  - state ← INIT, ptr ← 0, q_valid ← 0.
  - we and re on that edge are ignored; no write and no read occur.
- RUN, clr = 0, write: if we = 1, mem[wr_add] ← d.
- RUN, clr = 0, read:
  - If re = 1, q ← mem[rd_add] and q_valid ← 1.
  - If re = 0, q holds and q_valid ← 0.
- Collision (we = re = 1 and wr_add == rd_add in the same cycle):
  - BYPASS = 1: q ← d.
  - BYPASS = 0: q ← the pre-write contents.
  - The write always completes.
- Different addresses on the two ports never interact.
- Addresses are unsigned and cover the full 2**ADDR_W range; there is no out-of-range case.

## Timing
- Read latency is 1 cycle. re and rd_add sampled at edge N give q and q_valid at edge N (visible after N), held until the next edge.
- Write latency is 1 cycle. A write at edge N is readable by a read issued at edge N+1 on any mode. At edge N itself, collision rules apply.
- Clear duration:
  - After rst falls, INIT spans exactly DEPTH edges; init_busy falls after the DEPTH-th edge with rst = 0.
  - A clr pulse gives the same: clr edge, then DEPTH clearing edges.
- Reset mid-INIT restarts the sequence from ptr = 0. Words already cleared stay cleared.
- Reset in RUN: memory contents survive until INIT overwrites them.
- Throughput is one write and one read per cycle in RUN. Back-to-back reads give continuous q_valid.

## Test plan
Run with ADDR_W = 4 (DEPTH = 16), DATA_W = 8, CLR_VAL = 8'hA5, both BYPASS values.

1. Reset and clear:
   - Stimulus: rst high for 2 edges, then low; count edges.
   - Required: init_busy = 1 for exactly 16 edges after release, then 0.
   - Required: reads of addresses 0..15 return 8'hA5; q = 0 and q_valid = 0 until the first read.
2. Basic write and read:
   - Stimulus: write 8'hD3 to address 2; next cycle read address 3, then address 2.
   - Required: q = 8'hA5 then 8'hD3, each with q_valid = 1 one cycle after re.
3. Collision:
   - Stimulus: address 5 holds 8'h11; write 8'h22 to address 5 and read address 5 in the same cycle.
   - Required: q = 8'h22 (BYPASS = 1) or 8'h11 (BYPASS = 0); a following read returns 8'h22 in both modes.
4. Ignored ports during INIT:
   - Stimulus: pulse clr, then drive we = 1, wr_add = 7, d = 8'hFF and re = 1 during INIT.
   - Required: q_valid stays 0; after INIT, address 7 reads 8'hA5.
5. Reset mid-INIT:
   - Stimulus: assert rst at clearing edge 8, release it.
   - Required: a further 16 clearing edges before init_busy falls; all words read 8'hA5.
6. Streaming:
   - Stimulus: 16 back-to-back writes of value (addr ^ 8'h3C), then 16 back-to-back reads.
   - Required: q_valid high for 16 consecutive cycles with matching data.
